// File: rtl/spi_frame_sequencer.sv
// spi_frame_sequencer: turns length-prefixed UART frames into SPI transfers and returns MISO bytes through a response FIFO.
// Optional macro STATUS_BYTE_EN appends a status byte (8'h00 ok, 8'hE1 timeout) after each frame's responses.
module spi_frame_sequencer #(
  parameter int MAX_LEN        = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_done,
  input  logic [7:0] uart_data,
  input  logic       spi_done,
  input  logic [7:0] spi_rx_data,
  input  logic       tx_busy,
  output logic       spi_start,
  output logic [7:0] spi_tx_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       frame_active,
  output logic [4:0] bytes_left,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       err_len
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_SPI_ISSUE = 3'd2,
    ST_SPI_WAIT  = 3'd3
`ifdef STATUS_BYTE_EN
    , ST_STATUS  = 3'd4
`endif
  } main_state_t;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_PULSE   = 2'd1,
    TX_WAIT_HI = 2'd2,
    TX_WAIT_LO = 2'd3
  } tx_state_t;

  main_state_t      main_state_r, main_next_s;
  tx_state_t        tx_state_r, tx_next_s;
  logic             hold_full_r;
  logic [7:0]       hold_data_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [7:0]       fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] fifo_cnt_r;

  logic       hold_take_s, issue_s, push_s, pop_s;
  logic [7:0] push_data_s;
  logic       frame_start_s, frame_end_s, len_err_s, timeout_s, byte_done_s;
  logic       overrun_s;
`ifdef STATUS_BYTE_EN
  logic       status_load_s;
  logic [7:0] status_val_s;
  logic [7:0] status_r;
`endif

  assign overrun_s = uart_done & hold_full_r;

  // Main frame FSM: next state and per-cycle action strobes.
  always_comb begin
    main_next_s   = main_state_r;
    hold_take_s   = 1'b0;
    issue_s       = 1'b0;
    push_s        = 1'b0;
    push_data_s   = spi_rx_data;
    frame_start_s = 1'b0;
    frame_end_s   = 1'b0;
    len_err_s     = 1'b0;
    timeout_s     = 1'b0;
    byte_done_s   = 1'b0;
`ifdef STATUS_BYTE_EN
    status_load_s = 1'b0;
    status_val_s  = 8'h00;
`endif
    case (main_state_r)
      ST_IDLE: begin
        if (hold_full_r) begin
          hold_take_s = 1'b1;
          if ((hold_data_r == 8'd0) || (hold_data_r > MAX_LEN_B)) begin
            len_err_s = 1'b1;
          end else begin
            frame_start_s = 1'b1;
            main_next_s   = ST_WAIT_DATA;
          end
        end else begin
          main_next_s = ST_IDLE;
        end
      end
      ST_WAIT_DATA: begin
        // A FIFO slot is reserved before issuing so the response push can never overflow.
        if (hold_full_r) begin
          if (fifo_cnt_r < FIFO_FULL) begin
            hold_take_s = 1'b1;
            issue_s     = 1'b1;
            main_next_s = ST_SPI_ISSUE;
          end else begin
            main_next_s = ST_WAIT_DATA;
          end
        end else if (tmo_cnt_r >= TMO_LIMIT) begin
          timeout_s = 1'b1;
`ifdef STATUS_BYTE_EN
          status_load_s = 1'b1;
          status_val_s  = 8'hE1;
          main_next_s   = ST_STATUS;
`else
          frame_end_s = 1'b1;
          main_next_s = ST_IDLE;
`endif
        end else begin
          main_next_s = ST_WAIT_DATA;
        end
      end
      ST_SPI_ISSUE: main_next_s = ST_SPI_WAIT;
      ST_SPI_WAIT: begin
        if (spi_done) begin
          push_s      = 1'b1;
          byte_done_s = 1'b1;
          if (bytes_left == 5'd1) begin
`ifdef STATUS_BYTE_EN
            status_load_s = 1'b1;
            status_val_s  = 8'h00;
            main_next_s   = ST_STATUS;
`else
            frame_end_s = 1'b1;
            main_next_s = ST_IDLE;
`endif
          end else begin
            main_next_s = ST_WAIT_DATA;
          end
        end else begin
          main_next_s = ST_SPI_WAIT;
        end
      end
`ifdef STATUS_BYTE_EN
      ST_STATUS: begin
        if (fifo_cnt_r < FIFO_FULL) begin
          push_s      = 1'b1;
          push_data_s = status_r;
          frame_end_s = 1'b1;
          main_next_s = ST_IDLE;
        end else begin
          main_next_s = ST_STATUS;
        end
      end
`endif
      default: main_next_s = ST_IDLE;
    endcase
  end

  // Main FSM state, holding register, inter-byte timer and frame status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_state_r <= ST_IDLE;
      hold_full_r  <= 1'b0;
      hold_data_r  <= 8'h00;
      tmo_cnt_r    <= '0;
      spi_start    <= 1'b0;
      spi_tx_data  <= 8'h00;
      frame_active <= 1'b0;
      bytes_left   <= 5'd0;
      err_len      <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
`ifdef STATUS_BYTE_EN
      status_r     <= 8'h00;
`endif
    end else begin
      main_state_r <= main_next_s;
      if (hold_take_s) begin
        hold_full_r <= 1'b0;
      end else if (uart_done && !hold_full_r) begin
        hold_full_r <= 1'b1;
        hold_data_r <= uart_data;
      end
      if ((main_state_r != ST_WAIT_DATA) || timeout_s) begin
        tmo_cnt_r <= '0;
      end else if (!hold_full_r) begin
        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end
      spi_start <= issue_s;
      if (issue_s) begin
        spi_tx_data <= hold_data_r;
      end
      if (frame_start_s) begin
        frame_active <= 1'b1;
      end else if (frame_end_s) begin
        frame_active <= 1'b0;
      end
      if (frame_start_s) begin
        bytes_left <= hold_data_r[4:0];
      end else if (timeout_s) begin
        bytes_left <= 5'd0;
      end else if (byte_done_s) begin
        bytes_left <= bytes_left - 5'd1;
      end
      if (len_err_s) begin
        err_len <= 1'b1;
      end else if (frame_start_s) begin
        err_len <= 1'b0;
      end
      if (timeout_s) begin
        err_timeout <= 1'b1;
      end else if (frame_start_s) begin
        err_timeout <= 1'b0;
      end
      if (overrun_s) begin
        err_overrun <= 1'b1;
      end else if (frame_start_s) begin
        err_overrun <= 1'b0;
      end
`ifdef STATUS_BYTE_EN
      if (status_load_s) begin
        status_r <= status_val_s;
      end
`endif
    end
  end

  // Response FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // TX drain FSM: pops on entry to TX_PULSE, then tracks one full tx_busy high/low cycle.
  always_comb begin
    tx_next_s = tx_state_r;
    pop_s     = 1'b0;
    case (tx_state_r)
      TX_IDLE: begin
        if ((fifo_cnt_r != '0) && !tx_busy) begin
          pop_s     = 1'b1;
          tx_next_s = TX_PULSE;
        end else begin
          tx_next_s = TX_IDLE;
        end
      end
      TX_PULSE: tx_next_s = TX_WAIT_HI;
      TX_WAIT_HI: begin
        if (tx_busy) begin
          tx_next_s = TX_WAIT_LO;
        end else begin
          tx_next_s = TX_WAIT_HI;
        end
      end
      TX_WAIT_LO: begin
        if (!tx_busy) begin
          tx_next_s = TX_IDLE;
        end else begin
          tx_next_s = TX_WAIT_LO;
        end
      end
      default: tx_next_s = TX_IDLE;
    endcase
  end

  // TX FSM state and registered uart_tx strobe/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_r <= TX_IDLE;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      tx_state_r <= tx_next_s;
      tx_start   <= pop_s;
      if (pop_s) begin
        tx_data <= fifo_mem_r[rd_ptr_r];
      end
    end
  end

endmodule
